// File: rtl/seq_pkg.sv
// Shared defaults, register map constants, state encoding and helpers
// for the phase sequencer and its phase timer.
package seq_pkg;

  localparam int NPH_DEF     = 8;
  localparam int NOUT_DEF    = 6;
  localparam int TW_DEF      = 20;
  localparam int MAX_PH      = 16;
  localparam int ADDR_STRIDE = 4;

  localparam logic [5:0] NACT_ADDR   = 6'd62;
  localparam logic [5:0] REPEAT_ADDR = 6'd63;
  localparam logic [1:0] SUB_DUR_LO  = 2'd0;
  localparam logic [1:0] SUB_DUR_HI  = 2'd1;
  localparam logic [1:0] SUB_PAT     = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Limit a programmed phase count to the number of implemented phases.
  function automatic logic [4:0] clamp_nact(input logic [15:0] v, input logic [4:0] max_v);
    logic [4:0] r;
    if (v > {11'd0, max_v}) begin
      r = max_v;
    end else begin
      r = v[4:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase duration down-counter: load (zero treated as one), decrement on
// tick, terminal flag when the count reaches one.
module phase_timer
  import seq_pkg::*;
#(
  parameter int TW = TW_DEF
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  input  logic          tick_i,
  output logic [TW-1:0] count_o,
  output logic          term_o
);

  localparam logic [TW-1:0] ONE = {{(TW-1){1'b0}}, 1'b1};

  logic [TW-1:0] count_q, count_d;

  // Next count: clear, load or tick-driven decrement.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = (load_val_i == '0) ? ONE : load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign term_o  = (count_q == ONE);

endmodule

// File: rtl/phase_sequencer.sv
// Programmable phase sequencer: steps through NACT phases, each holding a
// pattern for a programmed number of timebase ticks, for REPEAT passes.
module phase_sequencer
  import seq_pkg::*;
#(
  parameter int NPH  = NPH_DEF,
  parameter int NOUT = NOUT_DEF,
  parameter int TW   = TW_DEF
) (
  input  logic            clk_sys,
  input  logic            rst_n,
  input  logic            clken_p,
  input  logic            load,
  input  logic [5:0]      loadchoice,
  input  logic [15:0]     datain,
  input  logic            start,
  input  logic            abort,
  output logic [NOUT-1:0] pattern,
  output logic [3:0]      phase_idx,
  output logic            busy,
  output logic            done,
  output logic [TW-1:0]   timecount
);

  logic [TW-1:0]     dur_q [MAX_PH];
  logic [NOUT-1:0]   pat_q [MAX_PH];
  logic [15:0]       nact_cfg_q;
  logic [15:0]       rep_cfg_q;
  logic [MAX_PH-1:0] wr_dur_lo_s, wr_dur_hi_s, wr_pat_s;
  logic              wr_nact_s, wr_rep_s, wr_phase_s;

  seq_state_e        state_q, state_d;
  logic [3:0]        phase_q, phase_d, phase_nx_s;
  logic [NOUT-1:0]   pattern_q, pattern_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [15:0]       pass_q, pass_d, rep_run_q, rep_run_d;
  logic [4:0]        nact_run_q, nact_run_d, nact_clamp_s;
  logic              last_s, final_s;

  logic              tmr_clr_s, tmr_load_s, tmr_tick_s, tmr_term_s;
  logic [TW-1:0]     tmr_val_s, tmr_count_s;

  // Address decode; NACT/REPEAT take precedence over the phase slots.
  always_comb begin
    wr_dur_lo_s = '0;
    wr_dur_hi_s = '0;
    wr_pat_s    = '0;
    wr_nact_s   = load && (loadchoice == NACT_ADDR);
    wr_rep_s    = load && (loadchoice == REPEAT_ADDR);
    wr_phase_s  = load && !wr_nact_s && !wr_rep_s;
    for (int i = 0; i < NPH; i++) begin
      wr_dur_lo_s[i] = wr_phase_s && (loadchoice == 6'(ADDR_STRIDE * i) + {4'd0, SUB_DUR_LO});
      wr_dur_hi_s[i] = wr_phase_s && (loadchoice == 6'(ADDR_STRIDE * i) + {4'd0, SUB_DUR_HI});
      wr_pat_s[i]    = wr_phase_s && (loadchoice == 6'(ADDR_STRIDE * i) + {4'd0, SUB_PAT});
    end
  end

  // Configuration registers, writable in any state.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_PH; i++) begin
        dur_q[i] <= '0;
        pat_q[i] <= '0;
      end
      nact_cfg_q <= 16'd0;
      rep_cfg_q  <= 16'd0;
    end else begin
      for (int i = 0; i < MAX_PH; i++) begin
        if (wr_dur_lo_s[i]) dur_q[i][15:0]    <= datain;
        if (wr_dur_hi_s[i]) dur_q[i][TW-1:16] <= datain[TW-17:0];
        if (wr_pat_s[i])    pat_q[i]          <= datain[NOUT-1:0];
      end
      if (wr_nact_s) nact_cfg_q <= datain;
      if (wr_rep_s)  rep_cfg_q  <= datain;
    end
  end

  assign nact_clamp_s = clamp_nact(nact_cfg_q, 5'(NPH));
  assign phase_nx_s   = phase_q + 4'd1;
  assign last_s       = ({1'b0, phase_q} == (nact_run_q - 5'd1));
  assign final_s      = last_s && (rep_run_q != 16'd0) && (pass_q == (rep_run_q - 16'd1));
  assign tmr_tick_s   = clken_p && (state_q == ST_RUN);

  // Sequencer next state; PAT and DUR are only sampled on phase entry.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    pattern_d  = pattern_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    nact_run_d = nact_run_q;
    rep_run_d  = rep_run_q;
    tmr_clr_s  = 1'b0;
    tmr_load_s = 1'b0;
    tmr_val_s  = dur_q[phase_nx_s];
    if (abort) begin
      state_d   = ST_IDLE;
      phase_d   = 4'd0;
      pattern_d = '0;
      busy_d    = 1'b0;
      pass_d    = 16'd0;
      tmr_clr_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && (nact_clamp_s != 5'd0)) begin
            state_d    = ST_RUN;
            busy_d     = 1'b1;
            phase_d    = 4'd0;
            pattern_d  = pat_q[4'd0];
            nact_run_d = nact_clamp_s;
            rep_run_d  = rep_cfg_q;
            pass_d     = 16'd0;
            tmr_load_s = 1'b1;
            tmr_val_s  = dur_q[4'd0];
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (clken_p && tmr_term_s) begin
            if (final_s) begin
              state_d   = ST_DONE;
              busy_d    = 1'b0;
              done_d    = 1'b1;
              phase_d   = 4'd0;
              pattern_d = '0;
              tmr_clr_s = 1'b1;
            end else if (last_s) begin
              phase_d    = 4'd0;
              pattern_d  = pat_q[4'd0];
              tmr_load_s = 1'b1;
              tmr_val_s  = dur_q[4'd0];
              pass_d     = (rep_run_q != 16'd0) ? (pass_q + 16'd1) : pass_q;
            end else begin
              phase_d    = phase_nx_s;
              pattern_d  = pat_q[phase_nx_s];
              tmr_load_s = 1'b1;
              tmr_val_s  = dur_q[phase_nx_s];
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d   = ST_IDLE;
          phase_d   = 4'd0;
          pattern_d = '0;
          busy_d    = 1'b0;
          tmr_clr_s = 1'b1;
        end
      endcase
    end
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= 4'd0;
      pattern_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 16'd0;
      nact_run_q <= 5'd0;
      rep_run_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      pattern_q  <= pattern_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      nact_run_q <= nact_run_d;
      rep_run_q  <= rep_run_d;
    end
  end

  phase_timer #(.TW(TW)) u_timer (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .clr_i      (tmr_clr_s),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .tick_i     (tmr_tick_s),
    .count_o    (tmr_count_s),
    .term_o     (tmr_term_s)
  );

  assign pattern   = pattern_q;
  assign phase_idx = phase_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timecount = tmr_count_s;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed self-checking bench for phase_sequencer.
module tb_phase_sequencer;

  localparam int NOUT = 6;
  localparam int TW   = 20;

  logic            clk_sys = 1'b0;
  logic            rst_n, clken_p, load, start, abort;
  logic [5:0]      loadchoice;
  logic [15:0]     datain;
  logic [NOUT-1:0] pattern;
  logic [3:0]      phase_idx;
  logic            busy, done;
  logic [TW-1:0]   timecount;

  int total = 0;
  int bad   = 0;

  int exp_pat  [10] = '{1, 1, 1, 1, 1, 2, 4, 4, 0, 0};
  int exp_tc   [10] = '{5, 4, 3, 2, 1, 1, 2, 1, 0, 0};
  int exp_ph   [10] = '{0, 0, 0, 0, 0, 1, 2, 2, 0, 0};
  int exp_busy [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  int exp_done [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

  always #5 clk_sys = ~clk_sys;

  phase_sequencer #(.NPH(8), .NOUT(NOUT), .TW(TW)) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .clken_p    (clken_p),
    .load       (load),
    .loadchoice (loadchoice),
    .datain     (datain),
    .start      (start),
    .abort      (abort),
    .pattern    (pattern),
    .phase_idx  (phase_idx),
    .busy       (busy),
    .done       (done),
    .timecount  (timecount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    load = 1'b1; loadchoice = a; datain = d;
    step();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " pattern"},   32'(pattern),   32'd0);
    chk({tag, " phase_idx"}, 32'(phase_idx), 32'd0);
    chk({tag, " busy"},      32'(busy),      32'd0);
    chk({tag, " done"},      32'(done),      32'd0);
    chk({tag, " timecount"}, 32'(timecount), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; clken_p = 1'b0; load = 1'b0; loadchoice = 6'd0;
    datain = 16'd0; start = 1'b0; abort = 1'b0;
    step(); step();
    chk_idle("reset");
    #2 rst_n = 1'b1;
    step();

    // Empty configuration: start must be ignored.
    pulse_start();
    chk("nact0 busy", 32'(busy), 32'd0);
    step();
    chk("nact0 done", 32'(done), 32'd0);

    // Single pass, DUR={5,0,2}, PAT={1,2,4}, tick every cycle.
    wr(6'd0, 16'd5); wr(6'd1, 16'd0); wr(6'd4, 16'd0); wr(6'd8, 16'd2);
    wr(6'd2, 16'h01); wr(6'd6, 16'h02); wr(6'd10, 16'h04);
    wr(6'd62, 16'd3); wr(6'd63, 16'd1);
    clken_p = 1'b1;
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("p1 pattern k=%0d", k),   32'(pattern),   32'(exp_pat[k]));
      chk($sformatf("p1 timecount k=%0d", k), 32'(timecount), 32'(exp_tc[k]));
      chk($sformatf("p1 phase k=%0d", k),     32'(phase_idx), 32'(exp_ph[k]));
      chk($sformatf("p1 busy k=%0d", k),      32'(busy),      32'(exp_busy[k]));
      chk($sformatf("p1 done k=%0d", k),      32'(done),      32'(exp_done[k]));
      step();
    end

    // Two passes with a tick every 4th cycle: pass is 32 cycles, done at 64.
    wr(6'd63, 16'd2);
    clken_p = 1'b0;
    pulse_start();
    for (int k = 0; k < 70; k++) begin
      int m;
      int ep;
      m  = k % 32;
      ep = (k >= 64) ? 0 : ((m < 20) ? 1 : ((m < 24) ? 2 : 4));
      chk($sformatf("p2 pattern k=%0d", k), 32'(pattern), 32'(ep));
      chk($sformatf("p2 done k=%0d", k),    32'(done),    32'(k == 64));
      chk($sformatf("p2 busy k=%0d", k),    32'(busy),    32'(k < 64));
      clken_p = ((k + 1) % 4 == 0);
      step();
    end

    // Continuous run over two phases, then abort during phase 1.
    wr(6'd63, 16'd0); wr(6'd62, 16'd2);
    clken_p = 1'b1;
    pulse_start();
    for (int k = 0; k < 24; k++) begin
      chk($sformatf("cont pattern k=%0d", k), 32'(pattern), 32'(((k % 6) < 5) ? 1 : 2));
      if (k < 23) step();
    end
    chk("cont phase before abort", 32'(phase_idx), 32'd1);
    pulse_abort();
    chk_idle("abort");
    step();
    chk("abort no done", 32'(done), 32'd0);

    // DUR[1] rewritten mid-phase; start while busy is ignored.
    wr(6'd4, 16'd3); wr(6'd0, 16'd2); wr(6'd63, 16'd2);
    pulse_start();
    for (int k = 0; k < 17; k++) begin
      int ep;
      ep = (k < 2) ? 1 : (k < 5) ? 2 : (k < 7) ? 1 : (k < 14) ? 2 : 0;
      chk($sformatf("mid pattern k=%0d", k), 32'(pattern), 32'(ep));
      chk($sformatf("mid done k=%0d", k),    32'(done),    32'(k == 14));
      chk($sformatf("mid busy k=%0d", k),    32'(busy),    32'(k < 14));
      if (k == 4) chk("mid old dur", 32'(timecount), 32'd1);
      if (k == 7) chk("mid new dur", 32'(timecount), 32'd7);
      load = (k == 2); loadchoice = 6'd4; datain = 16'd7;
      start = (k == 3);
      step();
    end
    load = 1'b0; start = 1'b0;

    // Start and abort together: abort wins.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk_idle("start+abort");
    step();
    chk("start+abort later busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a phase.
    wr(6'd63, 16'd0);
    pulse_start();
    step();
    chk("pre-reset busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async reset");
    step(); step();
    #2 rst_n = 1'b1;
    step();
    chk_idle("post reset");
    pulse_start();
    chk("post reset nact0 busy", 32'(busy), 32'd0);
    step();
    chk("post reset nact0 done", 32'(done), 32'd0);

    // Remaining config reads back as zero: PAT0=0, DUR0=0 -> 1, REPEAT=0 -> continuous.
    wr(6'd62, 16'd1);
    pulse_start();
    chk("rst cfg busy", 32'(busy), 32'd1);
    chk("rst cfg pattern", 32'(pattern), 32'd0);
    chk("rst cfg dur0", 32'(timecount), 32'd1);
    step();
    chk("rst cfg repeat0 busy", 32'(busy), 32'd1);
    chk("rst cfg wrap dur", 32'(timecount), 32'd1);
    pulse_abort();

    // Upper duration bits.
    wr(6'd0, 16'd3); wr(6'd1, 16'd1);
    pulse_start();
    chk("dur hi load", 32'(timecount), 32'h10003);
    step();
    chk("dur hi dec", 32'(timecount), 32'h10002);
    pulse_abort();
    chk_idle("final abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
